// File: rtl/stack_ctrl_if.sv
// Instruction-controller side of the operand stack: push/pop strobes, TOS and status.
interface stack_ctrl_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 2
);
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] tos_q;
   logic              ready;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              err_ovf;
   logic              err_unf;

   modport master (
      output push, pop, din,
      input  tos_q, ready, empty, full, count, err_ovf, err_unf
   );

   modport slave (
      input  push, pop, din,
      output tos_q, ready, empty, full, count, err_ovf, err_unf
   );
endinterface

// File: rtl/stack_ctrl.sv
// Operand stack controller: TOS cached in a register, lower entries spilled to a sync-read RAM.
// Optional STACK_CLR_EN adds a clr input that empties the stack without touching err_* or tos_q.
module stack_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
`ifdef STACK_CLR_EN
   input  logic              clr,
`endif
   stack_ctrl_if.slave       bus,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] CAP = (ADDR_W + 1)'(DEPTH + 1);

   typedef enum logic {IDLE, REFILL} state_t;

   state_t            state, state_n;
   logic [ADDR_W:0]   sp, sp_n, count;
   logic              tos_valid, tv_n;
   logic [DATA_W-1:0] tos_r, tos_n;
   logic              ovf_r, ovf_n, unf_r, unf_n;
   logic [ADDR_W-1:0] addr_hold, addr_c;
   logic              we_c;
   logic              is_empty, is_full;
   logic              clear;

`ifdef STACK_CLR_EN
   assign clear = clr;
`else
   assign clear = 1'b0;
`endif

   assign count    = sp + (ADDR_W + 1)'(tos_valid);
   assign is_empty = (count == '0);
   assign is_full  = (count == CAP);

   always_comb begin
      state_n = state;
      sp_n    = sp;
      tv_n    = tos_valid;
      tos_n   = tos_r;
      ovf_n   = ovf_r;
      unf_n   = unf_r;
      we_c    = 1'b0;
      addr_c  = addr_hold;
      if (clear) begin
         sp_n    = '0;
         tv_n    = 1'b0;
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.push && bus.pop) begin
                  // on an empty stack a push+pop degrades to a plain push
                  tos_n = bus.din;
                  if (is_empty) begin
                     tv_n  = 1'b1;
                     unf_n = 1'b1;
                  end
               end else if (bus.push) begin
                  if (is_empty) begin
                     tos_n = bus.din;
                     tv_n  = 1'b1;
                  end else if (!is_full) begin
                     we_c   = 1'b1;
                     addr_c = sp[ADDR_W-1:0];
                     sp_n   = sp + 1'b1;
                     tos_n  = bus.din;
                  end else begin
                     ovf_n = 1'b1;
                  end
               end else if (bus.pop) begin
                  if (is_empty) begin
                     unf_n = 1'b1;
                  end else if (sp == '0) begin
                     tv_n = 1'b0;
                  end else begin
                     // read address issued now, data lands during REFILL
                     addr_c  = sp[ADDR_W-1:0] - 1'b1;
                     state_n = REFILL;
                  end
               end
            end
            REFILL: begin
               tos_n   = ram_rdata;
               sp_n    = sp - 1'b1;
               state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sp        <= '0;
         tos_valid <= 1'b0;
         tos_r     <= '0;
         ovf_r     <= 1'b0;
         unf_r     <= 1'b0;
         addr_hold <= '0;
      end else begin
         state     <= state_n;
         sp        <= sp_n;
         tos_valid <= tv_n;
         tos_r     <= tos_n;
         ovf_r     <= ovf_n;
         unf_r     <= unf_n;
         addr_hold <= addr_c;
      end
   end

   assign ram_addr    = addr_c;
   assign ram_we      = we_c & ~rst;
   assign ram_wdata   = tos_r;

   assign bus.tos_q   = tos_r;
   assign bus.ready   = (state == IDLE);
   assign bus.empty   = is_empty;
   assign bus.full    = is_full;
   assign bus.count   = count;
   assign bus.err_ovf = ovf_r;
   assign bus.err_unf = unf_r;
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: per-cycle vector table with a scoreboard queue, plus a LIFO fill/drain sequence.
module tb_stack_ctrl;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 2;
   localparam logic T = 1'b1;
   localparam logic F = 1'b0;
   localparam int NV = 24;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] mem [4];
`ifdef STACK_CLR_EN
   logic clr = 1'b0;
`endif

   always #5 clk = ~clk;

   stack_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   stack_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef STACK_CLR_EN
      .clr       (clr),
`endif
      .bus       (bus),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // single-port RAM with registered read
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   typedef struct {
      logic       rst, push, pop;
      logic [7:0] din;
      logic       ck_dur, we;
      logic [1:0] addr;
      logic [7:0] wdata;
      logic       rdy;
      logic [7:0] tos;
      logic [2:0] cnt;
      logic       rdy_a, ovf, unf;
   } vec_t;

   typedef struct {
      int         idx;
      logic [7:0] tos;
      logic [2:0] cnt;
      logic       rdy, ovf, unf;
   } exp_t;

   vec_t       tbl [NV];
   exp_t       sb [$];
   logic [7:0] model [$];
   int         n_vec = 0;
   int         n_err = 0;

   function automatic vec_t mk(input logic r, p, q, input logic [7:0] d,
                               input logic cd, w, input logic [1:0] a, input logic [7:0] wd,
                               input logic rd, input logic [7:0] t, input logic [2:0] c,
                               input logic ra, o, u);
      vec_t v;
      v.rst = r; v.push = p; v.pop = q; v.din = d;
      v.ck_dur = cd; v.we = w; v.addr = a; v.wdata = wd; v.rdy = rd;
      v.tos = t; v.cnt = c; v.rdy_a = ra; v.ovf = o; v.unf = u;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, p, q, input logic [7:0] d);
      rst = r; bus.push = p; bus.pop = q; bus.din = d;
   endtask

   initial begin
      exp_t       e;
      logic [7:0] v;
      int         t;

      drive(F, F, F, 8'h00);

      //          rst push pop din    dur we addr  wdata  rdy  tos    cnt  rdyA ovf unf
      tbl[0]  = mk(T, F, F, 8'h00,   F, F, 2'd0, 8'h00, T,   8'h00, 3'd0, T, F, F);
      tbl[1]  = mk(F, T, F, 8'h11,   T, F, 2'd0, 8'h00, T,   8'h11, 3'd1, T, F, F);
      tbl[2]  = mk(F, T, F, 8'h22,   T, T, 2'd0, 8'h11, T,   8'h22, 3'd2, T, F, F);
      tbl[3]  = mk(F, F, T, 8'h00,   T, F, 2'd0, 8'h00, T,   8'h22, 3'd2, F, F, F);
      tbl[4]  = mk(F, F, F, 8'h00,   T, F, 2'd0, 8'h00, F,   8'h11, 3'd1, T, F, F);
      tbl[5]  = mk(F, F, T, 8'h00,   T, F, 2'd0, 8'h00, T,   8'h11, 3'd0, T, F, F);
      tbl[6]  = mk(F, T, F, 8'h01,   T, F, 2'd0, 8'h00, T,   8'h01, 3'd1, T, F, F);
      tbl[7]  = mk(F, T, F, 8'h02,   T, T, 2'd0, 8'h01, T,   8'h02, 3'd2, T, F, F);
      tbl[8]  = mk(F, T, F, 8'h03,   T, T, 2'd1, 8'h02, T,   8'h03, 3'd3, T, F, F);
      tbl[9]  = mk(F, T, F, 8'h04,   T, T, 2'd2, 8'h03, T,   8'h04, 3'd4, T, F, F);
      tbl[10] = mk(F, T, F, 8'h05,   T, T, 2'd3, 8'h04, T,   8'h05, 3'd5, T, F, F);
      tbl[11] = mk(F, T, F, 8'h06,   T, F, 2'd3, 8'h00, T,   8'h05, 3'd5, T, T, F);
      tbl[12] = mk(F, F, T, 8'h00,   T, F, 2'd3, 8'h00, T,   8'h05, 3'd5, F, T, F);
      tbl[13] = mk(F, F, F, 8'h00,   T, F, 2'd3, 8'h00, F,   8'h04, 3'd4, T, T, F);
      tbl[14] = mk(F, F, T, 8'h00,   T, F, 2'd2, 8'h00, T,   8'h04, 3'd4, F, T, F);
      tbl[15] = mk(F, T, T, 8'h99,   T, F, 2'd2, 8'h00, F,   8'h03, 3'd3, T, T, F);
      tbl[16] = mk(F, T, T, 8'h33,   T, F, 2'd2, 8'h00, T,   8'h33, 3'd3, T, T, F);
      tbl[17] = mk(F, T, T, 8'h44,   T, F, 2'd2, 8'h00, T,   8'h44, 3'd3, T, T, F);
      tbl[18] = mk(F, F, T, 8'h00,   T, F, 2'd1, 8'h00, T,   8'h44, 3'd3, F, T, F);
      tbl[19] = mk(T, F, F, 8'h00,   T, F, 2'd1, 8'h00, F,   8'h00, 3'd0, T, F, F);
      tbl[20] = mk(F, F, T, 8'h00,   T, F, 2'd0, 8'h00, T,   8'h00, 3'd0, T, F, T);
      tbl[21] = mk(F, T, T, 8'h7A,   T, F, 2'd0, 8'h00, T,   8'h7A, 3'd1, T, F, T);
      tbl[22] = mk(F, F, T, 8'h00,   T, F, 2'd0, 8'h00, T,   8'h7A, 3'd0, T, F, T);
      tbl[23] = mk(T, F, F, 8'h00,   F, F, 2'd0, 8'h00, F,   8'h00, 3'd0, T, F, F);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].din);
         #1;
         if (tbl[i].ck_dur) begin
            chk("ram_we", i, 32'(ram_we), 32'(tbl[i].we));
            chk("ram_addr", i, 32'(ram_addr), 32'(tbl[i].addr));
            chk("ready", i, 32'(bus.ready), 32'(tbl[i].rdy));
            if (tbl[i].we) chk("ram_wdata", i, 32'(ram_wdata), 32'(tbl[i].wdata));
         end
         e.idx = i; e.tos = tbl[i].tos; e.cnt = tbl[i].cnt;
         e.rdy = tbl[i].rdy_a; e.ovf = tbl[i].ovf; e.unf = tbl[i].unf;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk("tos_q", e.idx, 32'(bus.tos_q), 32'(e.tos));
         chk("count", e.idx, 32'(bus.count), 32'(e.cnt));
         chk("empty", e.idx, 32'(bus.empty), 32'(e.cnt == 3'd0));
         chk("full", e.idx, 32'(bus.full), 32'(e.cnt == 3'd5));
         chk("ready_after", e.idx, 32'(bus.ready), 32'(e.rdy));
         chk("err_ovf", e.idx, 32'(bus.err_ovf), 32'(e.ovf));
         chk("err_unf", e.idx, 32'(bus.err_unf), 32'(e.unf));
      end

      // spilled entries from the 0x01..0x05 fill are still in the RAM
      for (int k = 0; k < 4; k++) chk("ram_content", k, 32'(mem[k]), 32'(k + 1));

      // LIFO fill to capacity with random data, one overflow attempt, then drain
      @(negedge clk);
      drive(F, F, F, 8'h00);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         v = 8'($urandom_range(255, 0));
         drive(F, T, F, v);
         if (k < 5) model.push_back(v);
      end
      @(negedge clk);
      drive(F, F, F, 8'h00);
      chk("seq_full", 0, 32'(bus.full), 32'(1));
      chk("seq_ovf", 0, 32'(bus.err_ovf), 32'(1));
      chk("seq_tos", 0, 32'(bus.tos_q), 32'(model[4]));
      for (int k = 0; k < 5; k++) begin
         t = 0;
         while (!bus.ready && t < 8) begin
            @(negedge clk);
            t++;
         end
         chk("seq_ready_wait", k, 32'(bus.ready), 32'(1));
         drive(F, F, T, 8'h00);
         #1;
         chk("seq_pop_data", k, 32'(bus.tos_q), 32'(model.pop_back()));
         @(negedge clk);
         drive(F, F, F, 8'h00);
      end
      @(negedge clk);
      chk("seq_empty", 0, 32'(bus.empty), 32'(1));
      chk("seq_count", 0, 32'(bus.count), 32'(0));
      chk("seq_unf", 0, 32'(bus.err_unf), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Controller for the operand stack of the stack-machine datapath.
- Caches the top-of-stack (TOS) in a register and spills/refills the lower entries to a single-port synchronous-read stack RAM.
- Converts the main controller's single-cycle push/pop strobes into RAM sequencing, with a ready handshake and overflow/underflow detection.
- Sits between the instruction controller (push/pop/tos) and the stack RAM.

Parameters:
- DATA_W, 8, stack word width.
- ADDR_W, 2, stack RAM address width. RAM depth DEPTH = 2**ADDR_W.
- Total capacity is DEPTH+1 entries: the RAM plus the TOS register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  push request; honoured only when ready=1.
- pop  in  1  pop request; honoured only when ready=1.
- din  in  DATA_W  value to push.
- tos_q  out  DATA_W  current top-of-stack; valid when empty=0.
- ready  out  1  controller can accept a request this cycle.
- empty  out  1  count==0.
- full  out  1  count==DEPTH+1.
- count  out  ADDR_W+1  number of stacked entries.
- err_ovf  out  1  sticky: push attempted while full.
- err_unf  out  1  sticky: pop attempted while empty.
- ram_addr  out  ADDR_W  stack RAM address.
- ram_we  out  1  stack RAM write enable.
- ram_wdata  out  DATA_W  stack RAM write data.
- ram_rdata  in  DATA_W  stack RAM read data, registered: valid one cycle after address.

Behaviour:
- Internal state:
  - sp (ADDR_W+1 bits): number of entries held in the RAM.
  - tos_valid.
  - tos_q.
  - FSM state.
- count = sp + tos_valid.
- Reset: sp=0, tos_valid=0, tos_q=0, err_ovf=0, err_unf=0, state=IDLE. Outputs after reset: ready=1, empty=1, full=0, ram_we=0, ram_addr=0.
- FSM states:
  - IDLE: ready=1.
  - REFILL: ready=0, lasts exactly 1 cycle, then returns to IDLE.
- Consumer samples tos_q in the same cycle it asserts pop. The popped value is the pre-pop tos_q.
- IDLE actions, evaluated in priority order:
  - push & pop, not empty: replace. tos_q<=din, sp unchanged, no RAM access, 1 cycle.
  - push & pop, empty: treated as push; err_unf<=1.
  - push, empty: tos_q<=din, tos_valid<=1.
  - push, not full, tos_valid=1: spill. ram_we=1, ram_addr=sp[ADDR_W-1:0], ram_wdata=tos_q; then sp<=sp+1, tos_q<=din. Single cycle.
  - push, full: ignored; err_ovf<=1; no RAM write; tos_q, count unchanged.
  - pop, empty: ignored; err_unf<=1.
  - pop, sp==0, count==1: tos_valid<=0; stays IDLE.
  - pop, sp>0: ram_addr=sp-1 (read), ram_we=0; go to REFILL.
- REFILL: tos_q<=ram_rdata, sp<=sp-1, return to IDLE. Pop latency is 2 cycles to the new TOS.
- Requests while ready=0 are ignored: no state change, no error flag.
- ram_addr holds its last value when unused. ram_we is 0 except in the spill cycle.
- err_* are sticky and cleared only by rst.
- rst has priority over every action, including mid-REFILL: the next cycle is IDLE and empty, and the pending refill is discarded.
- sp never exceeds DEPTH and never underflows below 0.

Optional Feature:
- Macro: STACK_CLR_EN.
- Defined: adds input port clr (1 bit). When clr=1 in any state: next cycle sp=0, tos_valid=0, state=IDLE, no RAM write. err_* and tos_q are retained. Priority: below rst, above push/pop.
- Undefined: no clr port; the stack empties only via pops or rst.

Test Plan:
- ADDR_W=2 for all scenarios (capacity 5).
- Reset, push 0x11, then push 0x22 → second push cycle: ram_we=1, ram_addr=0, ram_wdata=0x11. Afterwards tos_q=0x22, count=2, ready=1.
- From count=2 (0x11 in RAM, TOS 0x22), pop → cycle 1: ready=0, ram_addr=0, ram_we=0. Cycle 2: tos_q=0x11, count=1, ready=1. Second pop → count=0, empty=1, no RAM access.
- Push 0x01..0x05 → full=1, count=5, RAM[0..3]=0x01..0x04, tos_q=0x05. Push 0x06 → err_ovf=1, tos_q=0x05, count=5, ram_we stays 0.
- From empty, pop → err_unf=1, count=0. Push & pop with din=0x7A → tos_q=0x7A, count=1, err_unf remains 1.
- At count=3 with tos_q=0x33, push & pop with din=0x44 → tos_q=0x44, count=3, ram_we=0, ready=1 throughout.
- At count=3, pop, then assert rst in the REFILL cycle → next cycle: count=0, empty=1, ready=1, err_ovf=err_unf=0, tos_q=0.
